pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Program counter and run-control for the single-cycle core.
//   - Holds the instruction-fetch PC.
//   - Advances the PC sequentially.
//   - On a taken branch, loads the absolute target from the branch-target LUT.
//   - Runs a start/done handshake with the test harness (IDLE/RUN/HALTED).
//   - Consumes the LUT target directly and drives the LUT branch-enable.
// PARAMETERS
//   D          8     PC / branch-target width; instruction memory depth is 2**D
//   CW         16    width of the cycle counter
//   START_PC   0     PC loaded when a program is launched
// PORTS
//   clk           in   1    system clock, all state updates on rising edge
//   reset         in   1    asynchronous, active-high reset
//   start         in   1    launch request (sampled in IDLE and HALTED only)
//   stall         in   1    hold PC this cycle (multi-cycle op in progress)
//   branch_taken  in   1    decoded branch with condition true, this cycle
//   target        in   D    absolute branch target from LUT (valid when lut_branch=1)
//   halt          in   1    current instruction is HALT
//   pc            out  D    instruction-fetch address (registered)
//   lut_branch    out  1    branch enable to target LUT (combinational)
//   running       out  1    1 while state==RUN
//   done          out  1    registered, 1 while state==HALTED
//   wrap_err      out  1    sticky: PC incremented past 2**D-1
//   cycle_count   out  CW   cycles spent in RUN for current/last program
// BEHAVIOUR
//   Reset
//     - Asynchronous, any time, including mid-program.
//     - state=IDLE, pc=START_PC, done=0, wrap_err=0, cycle_count=0.
//   States: IDLE, RUN, HALTED (2-bit register).
//     - running = (state==RUN); done = (state==HALTED).
//   IDLE
//     - pc holds START_PC.
//     - start=1 -> RUN next edge; pc=START_PC, cycle_count=0, wrap_err=0.
//   RUN: one PC update per edge. Priority, highest first:
//     1. halt=1         -> HALTED; pc holds (points at HALT); cycle_count+1.
//     2. stall=1        -> pc holds; cycle_count+1.
//     3. branch_taken=1 -> pc=target; cycle_count+1.
//     4. otherwise      -> pc=pc+1, mod 2**D; cycle_count+1.
//     - Case 4 from pc==2**D-1 wraps pc to 0 and sets wrap_err (sticky until
//       next launch or reset).
//     - start is ignored while in RUN.
//     - Latency: first fetch at START_PC occurs in the first RUN cycle.
//       A branch observed in cycle N fetches target in cycle N+1 (no delay slot).
//   HALTED
//     - pc, cycle_count and wrap_err frozen; done=1 held.
//     - start=1 -> RUN next edge with the same init as from IDLE; done falls
//       on that same edge.
//   lut_branch = branch_taken & running & ~stall & ~halt
//     - LUT output is therefore 0 outside a taken branch.
//     - Do not use target unless lut_branch=1.
//   cycle_count saturates at 2**CW-1 (no wrap).
//   All inputs are synchronous to clk; no X propagation from target when
//   lut_branch=0.
// TESTING
//   1. Reset, then start pulse, then 5 cycles of plain instructions
//      -> pc = 0,1,2,3,4,5; running=1; done=0.
//   2. In RUN at pc=23, branch_taken=1, target=24 (FIND_BIT_LOOP)
//      -> lut_branch=1 same cycle; pc=24 next edge.
//   3. Same-cycle stall=1 and branch_taken=1 at pc=10
//      -> pc stays 10; lut_branch=0; branch applies when stall drops.
//   4. halt=1 at pc=64 after 70 RUN cycles -> done=1 next edge; pc=64 frozen;
//      cycle_count=71; start then relaunches (pc=0, done=0, count=0).
//   5. D=8, force pc=255 with no branch -> pc=0 next edge, wrap_err=1 and stays
//      set until the next start.
//   6. Assert reset mid-RUN at pc=37 -> pc=0, state IDLE, done=0 immediately,
//      without waiting for a clock edge; start ignored while reset=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter and run-control for the single-cycle core.
// Holds the fetch PC, sequences it (increment / branch / stall / halt) and runs
// the IDLE -> RUN -> HALTED start/done handshake with the test harness.
module pc_sequencer #(
  parameter int unsigned    D        = 8,
  parameter int unsigned    CW       = 16,
  parameter logic [D-1:0]   START_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [D-1:0]  target,
  input  logic          halt,
  output logic [D-1:0]  pc,
  output logic          lut_branch,
  output logic          running,
  output logic          done,
  output logic          wrap_err,
  output logic [CW-1:0] cycle_count
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRun    = 2'd1;
  localparam logic [1:0] StHalted = 2'd2;

  localparam logic [D-1:0]  PcMax  = '1;
  localparam logic [CW-1:0] CntMax = '1;

  logic [1:0]    state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic          wrap_q, wrap_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Decoded status and LUT enable; target is only consumed when lut_branch is high.
  always_comb begin
    running    = (state_q == StRun);
    done       = (state_q == StHalted);
    lut_branch = branch_taken & running & ~stall & ~halt;
  end

  // Next-state: launch from IDLE/HALTED, prioritised PC update while running.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wrap_d  = wrap_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StHalted: begin
        if (start) begin
          state_d = StRun;
          pc_d    = START_PC;
          cnt_d   = '0;
          wrap_d  = 1'b0;
        end
      end
      StRun: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (halt) begin
          // PC keeps pointing at the HALT instruction.
          state_d = StHalted;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (lut_branch) begin
          pc_d = target;
        end else begin
          pc_d = pc_q + 1'b1;
          if (pc_q == PcMax) begin
            wrap_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        pc_d    = START_PC;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= START_PC;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign wrap_err    = wrap_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes model predictions, monitors
// pop and compare against the DUT outputs.
module tb_pc_sequencer;

  localparam int D  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, start, stall, branch_taken, halt;
  logic [D-1:0]  target;
  logic [D-1:0]  pc;
  logic          lut_branch, running, done, wrap_err;
  logic [CW-1:0] cycle_count;

  always #5 clk = ~clk;

  pc_sequencer #(.D(D), .CW(CW), .START_PC('0)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .branch_taken (branch_taken),
    .target       (target),
    .halt         (halt),
    .pc           (pc),
    .lut_branch   (lut_branch),
    .running      (running),
    .done         (done),
    .wrap_err     (wrap_err),
    .cycle_count  (cycle_count)
  );

  typedef struct {
    int pc;
    bit run;
    bit dn;
    bit wrap;
    int cnt;
  } exp_t;

  exp_t sb[$];
  bit   lq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: abstract run flag, done flag, PC and counters.
  int m_pc = 0;
  bit m_run = 0, m_dn = 0, m_wrap = 0;
  int m_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_run = 0; m_dn = 0; m_wrap = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit s, input bit st, input bit bt, input int tg,
                            input bit h);
    if (reset) begin
      model_reset();
    end else if (!m_run) begin
      if (s) begin
        m_run = 1; m_dn = 0; m_pc = 0; m_cnt = 0; m_wrap = 0;
      end
    end else begin
      if (m_cnt < (2**CW) - 1) m_cnt++;
      if (h) begin
        m_run = 0;
        m_dn  = 1;
      end else if (!st) begin
        if (bt) begin
          m_pc = tg;
        end else begin
          if (m_pc == (2**D) - 1) m_wrap = 1;
          m_pc = (m_pc + 1) % (2**D);
        end
      end
    end
  endtask

  // One clock of stimulus with explicit reset level.
  task automatic cycr(input bit r, input bit s, input bit st, input bit bt, input int tg,
                      input bit h);
    exp_t e;
    @(negedge clk);
    reset = r; start = s; stall = st; branch_taken = bt; halt = h;
    target = tg[D-1:0];
    lq.push_back(!r && m_run && bt && !st && !h);
    model_step(s, st, bt, tg % (2**D), h);
    e.pc = m_pc; e.run = m_run; e.dn = m_dn; e.wrap = m_wrap; e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic cyc(input bit s, input bit st, input bit bt, input int tg, input bit h);
    cycr(1'b0, s, st, bt, tg, h);
  endtask

  task automatic plain(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask

  // Random inputs with start held low (for IDLE/HALTED freeze checks).
  task automatic rand_nostart(input int n);
    repeat (n) cyc(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, int'(pc), 0);
    chk({tag, "_running"}, int'(running), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_wrap"}, int'(wrap_err), 0);
    chk({tag, "_count"}, int'(cycle_count), 0);
  endtask

  // Combinational LUT enable, sampled after inputs settle.
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      #2;
      if (lq.size() > 0) begin
        e = lq.pop_front();
        chk("lut_branch", int'(lut_branch), int'(e));
      end
    end
  end

  // Registered outputs, sampled just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", int'(pc), e.pc);
        chk("running", int'(running), int'(e.run));
        chk("done", int'(done), int'(e.dn));
        chk("wrap_err", int'(wrap_err), int'(e.wrap));
        chk("cycle_count", int'(cycle_count), e.cnt);
      end
    end
  end

  initial begin
    reset = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    target = '0;
    #1 reset = 1'b1;
    #1 chk_reset_vals("por");
    model_reset();

    // Start ignored under reset, then idle with no start.
    cycr(1, 1, 0, 0, 0, 0);
    cycr(1, 1, 0, 0, 0, 0);
    rand_nostart(3);

    // Launch and sequential fetch 0..5.
    cyc(1, 0, 0, 0, 0);
    plain(5);

    // Stall beats branch at pc=10; branch lands once stall drops.
    plain(5);
    cyc(0, 1, 1, 99, 0);
    cyc(0, 0, 1, 99, 0);

    // Branch 23 -> 24.
    cyc(0, 0, 1, 23, 0);
    cyc(0, 0, 1, 24, 0);

    // Halt, relaunch, 70 RUN cycles ending at pc=64, halt there (count 71).
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    repeat (6) cyc(0, 1, 0, 0, 0);
    plain(64);
    cyc(0, 0, 1, 200, 1);
    rand_nostart(4);
    cyc(1, 0, 0, 0, 0);

    // Wrap past 255 sets sticky wrap_err; cleared by next launch.
    cyc(0, 0, 1, 254, 0);
    plain(4);
    cyc(0, 0, 0, 0, 1);
    rand_nostart(3);
    cyc(1, 0, 0, 0, 0);

    // Cycle counter saturation.
    repeat (260) cyc(0, 1, 0, 0, 0);
    plain(3);

    // Randomised traffic.
    repeat (500) begin
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 4) == 0, int'($urandom_range(0, 255)),
          $urandom_range(0, 29) == 0);
    end

    // Asynchronous reset mid-RUN at pc=37.
    if (!m_run) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 37, 0);
    @(negedge clk);
    #3;
    reset = 1'b1;
    start = 1'b0; stall = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    #1 chk_reset_vals("async");
    model_reset();
    cycr(1, 1, 0, 0, 0, 0);
    cycr(1, 1, 0, 0, 0, 0);
    plain(2);

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    chk("lq_drain", lq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
